// File: rtl/view_draw_scheduler_pkg.sv
// rtl/view_draw_scheduler_pkg.sv - shared widths, client indices and FSM encoding for the draw scheduler
package view_draw_scheduler_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 12;

    localparam logic [C_W-1:0] KEY_COLOR_DEF = 12'h000;

    // Client slots; background sits at 0 so it is painted underneath everything else.
    localparam int CL_BG      = 0;
    localparam int CL_GOLD    = 1;
    localparam int CL_STONE   = 2;
    localparam int CL_DIAMOND = 3;
    localparam int CL_HOOK    = 4;
    localparam int CL_NUM     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAUNCH,
        ST_RUN,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/view_draw_scheduler_watchdog.sv
// rtl/view_draw_scheduler_watchdog.sv - saturating per-client run-time watchdog
//
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   clear        zero the counter (client launch)
//   count_en     advance the counter (client running)
//   expired      counter has reached TIMEOUT-1
module draw_watchdog
    import view_draw_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 131072
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/view_draw_scheduler.sv
// rtl/view_draw_scheduler.sv - sequences draw engines onto the single VGA write port once per frame
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   frame_go              pulse starting one frame pass (ignored while busy)
//   client_en, key_en     per-client draw enable (latched on go) and colour-key enable
//   start, done           one-cycle launch pulse to / completion from each client
//   x_in, y_in, color_in  packed per-client pixel buses, we_in per-client write strobe
//   X_out, Y_out, Color_out, writeEn   registered VGA write port
//   busy, frame_done      pass in progress / one-cycle completion pulse
//   timeout_err           sticky per-client watchdog abort flags
module view_draw_scheduler
    import view_draw_scheduler_pkg::*;
#(
    parameter int             N_CLIENTS = 6,
    parameter int             TIMEOUT   = 131072,
    parameter logic [C_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     frame_go,
    input  logic [N_CLIENTS-1:0]     client_en,
    input  logic [N_CLIENTS-1:0]     key_en,
    output logic [N_CLIENTS-1:0]     start,
    input  logic [N_CLIENTS-1:0]     done,
    input  logic [X_W*N_CLIENTS-1:0] x_in,
    input  logic [Y_W*N_CLIENTS-1:0] y_in,
    input  logic [C_W*N_CLIENTS-1:0] color_in,
    input  logic [N_CLIENTS-1:0]     we_in,
    output logic [X_W-1:0]           X_out,
    output logic [Y_W-1:0]           Y_out,
    output logic [C_W-1:0]           Color_out,
    output logic                     writeEn,
    output logic                     busy,
    output logic                     frame_done,
    output logic [N_CLIENTS-1:0]     timeout_err
);

    localparam int SEL_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    // idx must be able to hold N_CLIENTS itself: that value marks the end of the scan.
    localparam int IDX_W = $clog2(N_CLIENTS + 1);

    sched_state_t          state, state_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [SEL_W-1:0]      sel;
    logic [N_CLIENTS-1:0]  en_q;
    logic                  hit_found;
    logic [IDX_W-1:0]      hit_idx;
    logic                  wd_clr, wd_en, wd_expired, set_err;
    logic [X_W-1:0]        cur_x;
    logic [Y_W-1:0]        cur_y;
    logic [C_W-1:0]        cur_c;

    assign sel = idx[SEL_W-1:0];

    assign cur_x = x_in[int'(sel)*X_W +: X_W];
    assign cur_y = y_in[int'(sel)*Y_W +: Y_W];
    assign cur_c = color_in[int'(sel)*C_W +: C_W];

    // Lowest latched client at or above idx; descending loop so the lowest match wins.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (en_q[i] && i >= int'(idx)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    draw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (wd_clr),
        .count_en (wd_en),
        .expired  (wd_expired)
    );

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        start      = '0;
        frame_done = 1'b0;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_go) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                if (hit_found) begin
                    idx_nx   = hit_idx;
                    state_nx = ST_LAUNCH;
                end else begin
                    state_nx = ST_FINISH;
                end
            end
            ST_LAUNCH: begin
                start[sel] = 1'b1;
                wd_clr     = 1'b1;
                state_nx   = ST_RUN;
            end
            ST_RUN: begin
                wd_en = 1'b1;
                // A real completion on the expiry cycle is not reported as a timeout.
                if (done[sel]) begin
                    idx_nx   = idx + 1'b1;
                    state_nx = ST_SCAN;
                end else if (wd_expired) begin
                    set_err  = 1'b1;
                    idx_nx   = idx + 1'b1;
                    state_nx = ST_SCAN;
                end
            end
            ST_FINISH: begin
                frame_done = 1'b1;
                idx_nx     = '0;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            en_q        <= '0;
            busy        <= 1'b0;
            timeout_err <= '0;
            X_out       <= '0;
            Y_out       <= '0;
            Color_out   <= '0;
            writeEn     <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            writeEn <= 1'b0;
            if (state == ST_IDLE && frame_go) begin
                en_q        <= client_en;
                timeout_err <= '0;
                busy        <= 1'b1;
            end
            if (state == ST_FINISH) busy <= 1'b0;
            if (set_err) timeout_err[sel] <= 1'b1;
            if (state == ST_RUN) begin
                X_out     <= cur_x;
                Y_out     <= cur_y;
                Color_out <= cur_c;
                // Transparency is judged on the live client colour, not the registered output.
                writeEn   <= we_in[sel] & ~(key_en[sel] & (cur_c == KEY_COLOR));
            end
        end
    end

endmodule

// File: tb/tb_view_draw_scheduler.sv
// tb/tb_view_draw_scheduler.sv - directed self-checking bench for view_draw_scheduler
module tb_view_draw_scheduler;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           frame_go = 1'b0;
    logic [N-1:0]   client_en = '0;
    logic [N-1:0]   key_en = '0;
    logic [N-1:0]   start;
    logic [N-1:0]   done;
    logic [9*N-1:0] x_in;
    logic [8*N-1:0] y_in;
    logic [12*N-1:0] color_in;
    logic [N-1:0]   we_in;
    logic [8:0]     X_out;
    logic [7:0]     Y_out;
    logic [11:0]    Color_out;
    logic           writeEn;
    logic           busy;
    logic           frame_done;
    logic [N-1:0]   timeout_err;

    view_draw_scheduler #(.N_CLIENTS(N), .TIMEOUT(64), .KEY_COLOR(12'h000)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_go    (frame_go),
        .client_en   (client_en),
        .key_en      (key_en),
        .start       (start),
        .done        (done),
        .x_in        (x_in),
        .y_in        (y_in),
        .color_in    (color_in),
        .we_in       (we_in),
        .X_out       (X_out),
        .Y_out       (Y_out),
        .Color_out   (Color_out),
        .writeEn     (writeEn),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Client stubs: done is raised on the 10th cycle after the start pulse is seen.
    int           scnt [N];
    logic [N-1:0] hang = '0;
    logic         man_on = 1'b0;
    logic [8:0]   man_x = '0;
    logic [7:0]   man_y = '0;
    logic [11:0]  man_c = '0;
    logic         man_we = 1'b0;

    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < N; i++) begin
            if (!resetn)              scnt[i] <= 0;
            else if (start[i])        scnt[i] <= 1;
            else if (scnt[i] == 10)   scnt[i] <= 0;
            else if (scnt[i] != 0)    scnt[i] <= scnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            done[i]           = (scnt[i] == 10) && !hang[i];
            x_in[9*i +: 9]    = 9'(i*20 + 3);
            y_in[8*i +: 8]    = 8'(i*10 + 2);
            color_in[12*i +: 12] = 12'(256*(i+1) + 171);
            we_in[i]          = 1'b1;
        end
        if (man_on) begin
            x_in[9 +: 9]      = man_x;
            y_in[8 +: 8]      = man_y;
            color_in[12 +: 12] = man_c;
            we_in[1]          = man_we;
        end
    end

    int start_log[$];
    int fd_cnt = 0;
    int we_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (start[i]) start_log.push_back(i);
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (writeEn)    we_cnt <= we_cnt + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic go(input logic [N-1:0] en);
        step();
        client_en = en;
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
    endtask

    task automatic wait_start(input int i, input string tag);
        int n;
        n = 0;
        while (!start[i] && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(start[i]), 1);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 1000) begin
            step();
            n++;
        end
        check(tag, 32'(frame_done), 1);
    endtask

    function automatic int log_at(input int k);
        return (start_log.size() > k) ? start_log[k] : -1;
    endfunction

    initial begin
        int base, wb, fb, n;

        // Reset state
        step();
        step();
        check("rst_start", 32'(start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_writeEn", 32'(writeEn), 0);
        check("rst_pixel", {X_out, Y_out, Color_out}, 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        resetn = 1'b1;
        step();

        // 1: all clients, in order, 10 RUN cycles each
        base = start_log.size(); wb = we_cnt; fb = fd_cnt;
        go(6'b111111);
        wait_frame_done("t1_frame_done");
        step(); step(); step();
        check("t1_start_count", start_log.size() - base, 6);
        for (int i = 0; i < N; i++) check($sformatf("t1_order_%0d", i), log_at(base + i), i);
        check("t1_writeEn_count", we_cnt - wb, 60);
        check("t1_frame_done_count", fd_cnt - fb, 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_last_x", 32'(X_out), 103);
        check("t1_last_color", 32'(Color_out), 12'h6AB);
        check("t1_timeout_err", 32'(timeout_err), 0);

        // 2: sparse enable
        base = start_log.size(); wb = we_cnt; fb = fd_cnt;
        go(6'b010010);
        wait_frame_done("t2_frame_done");
        step(); step();
        check("t2_start_count", start_log.size() - base, 2);
        check("t2_first", log_at(base), 1);
        check("t2_second", log_at(base + 1), 4);
        check("t2_writeEn_count", we_cnt - wb, 20);
        check("t2_frame_done_count", fd_cnt - fb, 1);

        // 3: colour-key transparency on client 1
        key_en = 6'b000010;
        man_on = 1'b1;
        man_we = 1'b0;
        go(6'b000010);
        wait_start(1, "t3_start1");
        step();
        man_x = 9'd5; man_y = 8'd7; man_c = 12'h000; man_we = 1'b1;
        step();
        check("t3_key_writeEn", 32'(writeEn), 0);
        check("t3_key_x", 32'(X_out), 5);
        man_x = 9'd6; man_y = 8'd7; man_c = 12'hFFF;
        step();
        check("t3_pix_writeEn", 32'(writeEn), 1);
        check("t3_pix_xy", {X_out, Y_out}, {9'd6, 8'd7});
        check("t3_pix_color", 32'(Color_out), 12'hFFF);
        man_we = 1'b0;
        wait_frame_done("t3_frame_done");
        man_on = 1'b0;
        key_en = '0;

        // 4: client 2 hangs, watchdog aborts after 64 RUN cycles
        hang = 6'b000100;
        go(6'b001100);
        wait_start(2, "t4_start2");
        n = 0;
        while (!start[3] && n < 200) begin
            step();
            n++;
        end
        check("t4_cycles_to_start3", n, 66);
        check("t4_timeout_err", 32'(timeout_err), 6'b000100);
        wait_frame_done("t4_frame_done");
        check("t4_err_sticky", 32'(timeout_err), 6'b000100);
        hang = '0;

        // 5: empty frame clears error, frame_done two cycles after go
        base = start_log.size();
        go(6'b000000);
        check("t5_err_cleared", 32'(timeout_err), 0);
        check("t5_busy_scan", 32'(busy), 1);
        check("t5_no_done_yet", 32'(frame_done), 0);
        step();
        check("t5_frame_done", 32'(frame_done), 1);
        step();
        check("t5_idle", {busy, frame_done}, 0);
        check("t5_no_start", start_log.size() - base, 0);

        // 5b: frame_go while busy is ignored
        base = start_log.size(); fb = fd_cnt;
        go(6'b000001);
        step();
        client_en = 6'b111111;
        frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        wait_frame_done("t5b_frame_done");
        step(); step(); step(); step(); step();
        check("t5b_start_count", start_log.size() - base, 1);
        check("t5b_only_client0", log_at(base), 0);
        check("t5b_frame_done_count", fd_cnt - fb, 1);
        check("t5b_not_busy", 32'(busy), 0);

        // 6: asynchronous reset during client 3
        go(6'b111111);
        wait_start(3, "t6_start3");
        step(); step(); step();
        check("t6_pre_x", 32'(X_out), 63);
        resetn = 1'b0;
        #1;
        check("t6_rst_ctrl", {start, busy, frame_done, writeEn}, 0);
        check("t6_rst_pixel", {X_out, Y_out, Color_out}, 0);
        check("t6_rst_err", 32'(timeout_err), 0);
        step();
        resetn = 1'b1;
        step();
        base = start_log.size();
        go(6'b111111);
        wait_start(0, "t6_restart");
        check("t6_first_client", log_at(base), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
